// File: rtl/uart_tx_driver.sv
// Testbench-side UART transmitter: byte FIFO feeding an 8-bit serialiser
// (start, LSB-first data, optional parity, 1-2 stop bits) timed by a 16x baud tick.
module uart_tx_driver #(
  parameter int DEPTH     = 16,
  parameter int STOP_BITS = 1
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       tx_enable,
  input  logic                       tick_baud_x16,
  input  logic                       parity_enable,
  input  logic                       parity_odd,
  input  logic                       wr_valid,
  input  logic [7:0]                 wr_data,
  output logic                       wr_ready,
  output logic                       tx,
  output logic                       busy,
  output logic                       frame_done,
  output logic [$clog2(DEPTH+1)-1:0] level
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH+1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t        state, state_nxt;
  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [3:0]    tick_cnt, tick_cnt_nxt;
  logic [2:0]    bit_cnt, bit_cnt_nxt;
  logic          stop_cnt, stop_cnt_nxt;
  logic [7:0]    shreg, shreg_nxt;
  logic          par_en, par_en_nxt;
  logic          par_bit, par_bit_nxt;
  logic          tx_nxt, done_nxt;
  logic          push, pop, bit_end, can_load, last_stop;

  assign wr_ready  = (level != LW'(DEPTH));
  assign push      = wr_valid && wr_ready;
  assign bit_end   = tick_baud_x16 && (tick_cnt == 4'hf);
  assign can_load  = tx_enable && (level != '0);
  assign last_stop = (STOP_BITS == 1) || stop_cnt;

  always_comb begin
    state_nxt    = state;
    tick_cnt_nxt = tick_cnt;
    bit_cnt_nxt  = bit_cnt;
    stop_cnt_nxt = stop_cnt;
    shreg_nxt    = shreg;
    par_en_nxt   = par_en;
    par_bit_nxt  = par_bit;
    tx_nxt       = tx;
    done_nxt     = 1'b0;
    pop          = 1'b0;
    if (state != IDLE && tick_baud_x16) tick_cnt_nxt = tick_cnt + 4'd1;
    case (state)
      IDLE:   if (tick_baud_x16 && can_load) pop = 1'b1;
      START:  if (bit_end) begin
        state_nxt   = DATA;
        tx_nxt      = shreg[0];
        bit_cnt_nxt = 3'd0;
      end
      DATA:   if (bit_end) begin
        if (bit_cnt == 3'd7) begin
          state_nxt    = par_en ? PARITY : STOP;
          tx_nxt       = par_en ? par_bit : 1'b1;
          stop_cnt_nxt = 1'b0;
        end else begin
          shreg_nxt   = {1'b0, shreg[7:1]};
          tx_nxt      = shreg[1];
          bit_cnt_nxt = bit_cnt + 3'd1;
        end
      end
      PARITY: if (bit_end) begin
        state_nxt    = STOP;
        tx_nxt       = 1'b1;
        stop_cnt_nxt = 1'b0;
      end
      STOP:   if (bit_end) begin
        if (last_stop) begin
          done_nxt = 1'b1;
          // chain straight into the next frame so there is no idle gap
          if (can_load) pop = 1'b1;
          else          state_nxt = IDLE;
        end else begin
          stop_cnt_nxt = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (pop) begin
      state_nxt    = START;
      tx_nxt       = 1'b0;
      tick_cnt_nxt = 4'd0;
      shreg_nxt    = mem[rptr];
      par_en_nxt   = parity_enable;
      par_bit_nxt  = (^mem[rptr]) ^ parity_odd;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state      <= IDLE;
      tick_cnt   <= 4'd0;
      bit_cnt    <= 3'd0;
      stop_cnt   <= 1'b0;
      shreg      <= 8'h00;
      par_en     <= 1'b0;
      par_bit    <= 1'b0;
      tx         <= 1'b1;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      level      <= '0;
      wptr       <= '0;
      rptr       <= '0;
    end else begin
      state      <= state_nxt;
      tick_cnt   <= tick_cnt_nxt;
      bit_cnt    <= bit_cnt_nxt;
      stop_cnt   <= stop_cnt_nxt;
      shreg      <= shreg_nxt;
      par_en     <= par_en_nxt;
      par_bit    <= par_bit_nxt;
      tx         <= tx_nxt;
      busy       <= (state_nxt != IDLE);
      frame_done <= done_nxt;
      level      <= level + LW'(push) - LW'(pop);
      if (push) wptr <= wptr + AW'(1);
      if (pop)  rptr <= rptr + AW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) mem[wptr] <= wr_data;
  end
endmodule

// File: tb/tb_uart_tx_driver.sv
// Randomized bench: decodes the tx line by counting baud ticks and compares each
// frame with the queued byte and the parity setting in force at frame start.
module tb_uart_tx_driver;
  localparam int DEPTH = 16;
  localparam int STOP_BITS = 1;
  localparam int LW = $clog2(DEPTH+1);

  logic clk = 1'b0;
  logic rst_i = 1'b1, tx_enable = 1'b0, tick_baud_x16 = 1'b0;
  logic parity_enable = 1'b0, parity_odd = 1'b0, wr_valid = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic wr_ready, tx, busy, frame_done;
  logic [LW-1:0] level;

  int checks = 0, errors = 0;
  int tick_per = 1;
  logic cfg_pe_q = 1'b0, cfg_po_q = 1'b0;
  logic [11:0] last_bits;
  int last_busy, last_ticks;

  uart_tx_driver #(.DEPTH(DEPTH), .STOP_BITS(STOP_BITS)) dut (
    .clk_i(clk), .rst_i(rst_i), .tx_enable(tx_enable), .tick_baud_x16(tick_baud_x16),
    .parity_enable(parity_enable), .parity_odd(parity_odd), .wr_valid(wr_valid),
    .wr_data(wr_data), .wr_ready(wr_ready), .tx(tx), .busy(busy),
    .frame_done(frame_done), .level(level)
  );

  always #5 clk = ~clk;

  initial begin : tick_gen
    int tcnt;
    tcnt = 0;
    forever begin
      @(posedge clk); #1;
      tcnt++;
      tick_baud_x16 = ((tcnt % tick_per) == 0);
    end
  end

  // parity settings as seen by the design on each edge (frame-start sampling)
  always @(posedge clk) begin
    cfg_pe_q <= parity_enable;
    cfg_po_q <= parity_odd;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [7:0] b);
    wr_valid = 1'b1;
    wr_data  = b;
    @(posedge clk); #1;
    wr_valid = 1'b0;
  endtask

  // Receive one frame starting from a negedge; returns at the negedge after the last tick.
  task automatic recv_frame(input logic [7:0] b, input bit scramble, input bit drop_en, input bit b2b);
    int n, to, nbits;
    logic pe, po, stop_ok;
    logic [11:0] bits;
    to = 0;
    while (tx !== 1'b0 && to < 4000) begin @(negedge clk); to++; end
    check("start_seen", {31'd0, tx === 1'b0}, 32'd1);
    if (tx !== 1'b0) return;
    pe = cfg_pe_q;
    po = cfg_po_q;
    nbits = 9 + int'(pe) + STOP_BITS;
    n = 0; to = 0; bits = '1; last_busy = 0;
    forever begin
      if (busy) last_busy++;
      if (tick_baud_x16) begin
        n++;
        if ((n - 1) % 16 == 7) bits[(n - 1) / 16] = tx;
        if (n == 20 && drop_en) tx_enable = 1'b0;
        if (n == 40 && scramble) begin
          parity_enable = 1'($urandom);
          parity_odd    = 1'($urandom);
        end
      end
      if (n == 16 * nbits || to > 16 * nbits * 8) break;
      @(negedge clk); to++;
    end
    last_bits  = bits;
    last_ticks = n;
    check("frame_ticks", n, 16 * nbits);
    check("busy_hold", last_busy, to + 1);
    check("start_bit", {31'd0, bits[0]}, 32'd0);
    check("data", {24'd0, bits[8:1]}, {24'd0, b});
    if (pe) check("parity", {31'd0, bits[9]}, {31'd0, (^b) ^ po});
    stop_ok = 1'b1;
    for (int s = 0; s < STOP_BITS; s++) stop_ok &= bits[9 + int'(pe) + s];
    check("stop_bits", {31'd0, stop_ok}, 32'd1);
    check("done_early", {31'd0, frame_done}, 32'd0);
    @(negedge clk);
    check("frame_done", {31'd0, frame_done}, 32'd1);
    if (b2b) check("b2b_start", {31'd0, tx}, 32'd0);
  endtask

  initial begin
    logic [7:0] q[$];
    int to;
    // reset state
    repeat (3) @(posedge clk);
    #1 rst_i = 1'b0;
    @(negedge clk);
    check("rst_tx", {31'd0, tx}, 32'd1);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, frame_done}, 32'd0);
    check("rst_level", level, 0);
    check("rst_ready", {31'd0, wr_ready}, 32'd1);

    // single byte, no parity, tick every cycle
    push(8'h55);
    @(negedge clk);
    check("lvl_one", level, 1);
    tx_enable = 1'b1;
    recv_frame(8'h55, 1'b0, 1'b0, 1'b0);
    check("busy_160", last_busy, 160);
    check("bits_55", {20'd0, last_bits[9:0]}, 32'h2AA);
    check("idle_after", {30'd0, busy, tx}, 32'd1);
    tx_enable = 1'b0;

    // parity on 0x41: even then odd
    parity_enable = 1'b1; parity_odd = 1'b0;
    push(8'h41);
    tx_enable = 1'b1;
    recv_frame(8'h41, 1'b0, 1'b0, 1'b0);
    check("par_even_bit", {31'd0, last_bits[9]}, 32'd0);
    check("par_even_len", last_ticks, 176);
    tx_enable = 1'b0; parity_odd = 1'b1;
    push(8'h41);
    tx_enable = 1'b1;
    recv_frame(8'h41, 1'b0, 1'b0, 1'b0);
    check("par_odd_bit", {31'd0, last_bits[9]}, 32'd1);
    tx_enable = 1'b0; parity_enable = 1'b0; parity_odd = 1'b0;

    // full FIFO, overflow dropped, back-to-back drain
    for (int i = 0; i < 16; i++) push(8'(i));
    @(negedge clk);
    check("full_level", level, 16);
    check("full_ready", {31'd0, wr_ready}, 32'd0);
    push(8'h10);
    @(negedge clk);
    check("drop_level", level, 16);
    tx_enable = 1'b1;
    for (int i = 0; i < 16; i++) recv_frame(8'(i), 1'b0, 1'b0, i < 15);
    check("drain_level", level, 0);
    check("drain_busy", {31'd0, busy}, 32'd0);
    tx_enable = 1'b0;

    // tx_enable dropped mid-frame with two more queued
    for (int i = 0; i < 3; i++) push(8'hA0 + 8'(i));
    tx_enable = 1'b1;
    recv_frame(8'hA0, 1'b0, 1'b1, 1'b0);
    repeat (50) @(negedge clk);
    check("hold_level", level, 2);
    check("hold_tx", {31'd0, tx}, 32'd1);
    check("hold_busy", {31'd0, busy}, 32'd0);

    // reset mid-frame
    tx_enable = 1'b1;
    to = 0;
    while (tx !== 1'b0 && to < 200) begin @(negedge clk); to++; end
    repeat (30) @(negedge clk);
    check("pre_rst_busy", {31'd0, busy}, 32'd1);
    rst_i = 1'b1;
    @(negedge clk);
    check("mid_rst_tx", {31'd0, tx}, 32'd1);
    check("mid_rst_level", level, 0);
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    rst_i = 1'b0;
    tx_enable = 1'b0;

    // tick every 4 cycles, even parity: 'H', '\n', 0xFF
    tick_per = 4; parity_enable = 1'b1; parity_odd = 1'b0;
    push(8'h48); push(8'h0A); push(8'hFF);
    tx_enable = 1'b1;
    recv_frame(8'h48, 1'b0, 1'b0, 1'b1);
    recv_frame(8'h0A, 1'b0, 1'b0, 1'b1);
    recv_frame(8'hFF, 1'b0, 1'b0, 1'b0);
    tx_enable = 1'b0;

    // randomized rounds; parity inputs wander mid-frame
    for (int r = 0; r < 6; r++) begin
      tick_per = int'($urandom_range(1, 4));
      parity_enable = 1'($urandom);
      parity_odd    = 1'($urandom);
      q.delete();
      for (int i = 0; i < int'($urandom_range(1, 6)); i++) begin
        q.push_back(8'($urandom));
        push(q[$]);
      end
      @(negedge clk);
      check("rnd_level", level, q.size());
      tx_enable = 1'b1;
      for (int i = 0; i < q.size(); i++) recv_frame(q[i], 1'b1, 1'b0, i < q.size() - 1);
      tx_enable = 1'b0;
      check("rnd_drain", level, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
